// File: rtl/rsh_seq.sv
// Multi-cycle logical right shifter: one 1-bit shift per clock until the
// requested amount is consumed, with valid/ready handshakes on both sides.

module rsh_one #(
   parameter int W = 16
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   // Single logical right shift by one, zero fill at the MSB
   assign dout = din >> 1;

endmodule

module rsh_seq #(
   parameter int N = 4,
   parameter int W = 2**N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [N-1:0] in_amt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   data_q;
   logic [W-1:0]   data_shift;
   logic [N-1:0]   cnt_q;
   logic           load_en;
   logic           shift_en;
   logic           busy_q;

   // The one-bit stage sees the working register and its result is fed
   // straight back into that register on every SHIFT cycle.
   rsh_one #(
      .W(W)
   ) u_stage (
      .din  (data_q),
      .dout (data_shift)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A zero amount skips SHIFT entirely so the result appears one cycle
   // after the accept; otherwise the last shift happens when cnt is 1.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = (in_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == N'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load_en   = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            load_en  = in_valid;
         end
         SHIFT: begin
            shift_en = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (load_en) begin
         data_q <= in_data;
         cnt_q  <= in_amt;
      end else if (shift_en) begin
         data_q <= data_shift;
         cnt_q  <= cnt_q - N'(1);
      end
   end

   // Busy is tracked from the next state so it lines up with the state flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= (state_nxt != IDLE);
      end
   end

   assign busy     = busy_q;
   assign out_data = data_q;

endmodule

// File: tb/tb_rsh_seq.sv
// Scoreboard bench for rsh_seq: stimulus pushes hand-computed results,
// a negedge monitor compares whatever the DUT presents.

module tb_rsh_seq;

   localparam int N = 4;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] data;
      int           amt;
      int           accept;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [N-1:0] in_amt;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

   int   vectors;
   int   miscompares;
   int   cycle;
   int   hs_cycle;
   bit   seen;
   exp_t sb[$];

   rsh_seq #(
      .N(N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Holds the operand until accepted, then records the accepting edge
   task automatic applyStimulus(input logic [W-1:0] d, input logic [N-1:0] a,
                                input logic [W-1:0] expected);
      int waited;
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      waited   = 0;
      while (!in_ready && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.data   = expected;
      e.amt    = int'(a);
      e.accept = cycle;
      sb.push_back(e);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_amt   = N'($urandom);
   endtask

   task automatic waitDrain(input string name);
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput({name, "_drained"}, 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Monitor: compare every presented result, pop on handshake
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            if (!seen) begin
               checkOutput("latency", 32'(cycle - sb[0].accept + 1), 32'(sb[0].amt + 1));
               seen = 1'b1;
            end
            checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
            if (out_ready) begin
               void'(sb.pop_front());
               seen     = 1'b0;
               hs_cycle = cycle + 1;
            end
         end
      end
   end

   initial begin : stim
      int waited;
      vectors     = 0;
      miscompares = 0;
      seen        = 1'b0;
      hs_cycle    = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_amt      = '0;
      out_ready   = 1'b1;
      #12;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", 32'(out_data), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic, zero and max shifts");
      applyStimulus(16'hB3C5, 4'd1, 16'h59E2);
      waitDrain("basic");
      applyStimulus(16'hB3C5, 4'd0, 16'hB3C5);
      waitDrain("zero");
      applyStimulus(16'h8000, 4'd15, 16'h0001);
      waitDrain("max_8000");
      applyStimulus(16'hFFFF, 4'd15, 16'h0001);
      waitDrain("max_ffff");
      applyStimulus(16'hA5A5, 4'd7, 16'h014B);
      applyStimulus(16'h0001, 4'd1, 16'h0000);
      waitDrain("misc");

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(16'h00F0, 4'd4, 16'h000F);
      waited = 0;
      while (!out_valid && waited < 50) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput("bp_out_valid_seen", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_hold_data", 32'(out_data), 32'h000F);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
      checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] operand while busy");
      applyStimulus(16'hF0F0, 4'd6, 16'h03C3);
      @(posedge clk);
      #1;
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      checkOutput("busy_busy", 32'(busy), 32'd1);
      applyStimulus(16'hFFFF, 4'd3, 16'h1FFF);
      if (sb.size() != 0) begin
         checkOutput("busy_accept_after_hs", 32'(sb[sb.size()-1].accept), 32'(hs_cycle + 1));
      end
      waitDrain("busy");

      $display("[TB] reset mid-shift");
      applyStimulus(16'hAAAA, 4'd8, 16'h00AA);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_reset_out_data", 32'(out_data), 32'd0);
      checkOutput("mid_reset_busy", 32'(busy), 32'd0);
      checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      seen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
      applyStimulus(16'h1234, 4'd2, 16'h048D);
      waitDrain("after_reset");

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
